// File: rtl/press_classifier.sv
// -----------------------------------------------------------------------------
// press_classifier
//
// Turns the debounced button level into single-cycle gesture strobes:
//   short press  - press released, and no second press within the gap window
//   long press   - button held for LONG_MS milliseconds
//   double click - second press starting within the gap window
//
// Time is measured in milliseconds using an internal prescaler, so no
// external tick is needed.
//
// Parameters
//   TICK_M      clk cycles per 1 ms tick
//   LONG_MS     hold time (ms) that qualifies a long press
//   DCLICK_MS   maximum release gap (ms) for a double click
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   db           in   debounced button level, synchronous to clk
//   short_tick   out  one-cycle pulse: short press completed
//   long_tick    out  one-cycle pulse: long-press threshold reached
//   double_tick  out  one-cycle pulse: second press of a double click
//   busy         out  high while a gesture is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module press_classifier #(
   parameter int TICK_M    = 100_000,
   parameter int LONG_MS   = 500,
   parameter int DCLICK_MS = 250
) (
   input  logic clk,
   input  logic reset,
   input  logic db,
   output logic short_tick,
   output logic long_tick,
   output logic double_tick,
   output logic busy
);

   // ------------------------------------------------------------------------
   // Derived widths
   // ------------------------------------------------------------------------
   localparam int PRESC_W = (TICK_M > 1) ? $clog2(TICK_M) : 1;
   localparam int MS_MAX  = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
   localparam int MS_W    = $clog2(MS_MAX + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_M - 1);
   localparam logic [MS_W-1:0]    LONG_LAST  = MS_W'(LONG_MS - 1);
   localparam logic [MS_W-1:0]    GAP_LAST   = MS_W'(DCLICK_MS - 1);
   localparam logic [MS_W-1:0]    MS_SAT     = {MS_W{1'b1}};

   // ------------------------------------------------------------------------
   // State machine encoding
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HELD = 3'd2,
      GAP       = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   state_t               state_q,  state_d;
   logic [PRESC_W-1:0]   presc_q,  presc_d;
   logic [MS_W-1:0]      ms_cnt_q, ms_cnt_d;
   logic                 db_prev_q;
   logic                 short_q,  short_d;
   logic                 long_q,   long_d;
   logic                 double_q, double_d;

   logic                 rise;
   logic                 ms_tick;
   logic                 long_hit;
   logic                 gap_hit;

   // ------------------------------------------------------------------------
   // Edge detect and timer decode
   // ------------------------------------------------------------------------
   // db_prev resets high so a button held down through reset does not look
   // like a fresh press; it must be released and pressed again.
   assign rise     = db & ~db_prev_q;
   assign ms_tick  = (presc_q == PRESC_LAST);
   // Both thresholds fire on the ms tick that completes the final
   // millisecond, i.e. exactly N*TICK_M edges after the state was entered.
   assign long_hit = ms_tick & (ms_cnt_q == LONG_LAST);
   assign gap_hit  = ms_tick & (ms_cnt_q == GAP_LAST);

   // ------------------------------------------------------------------------
   // Next-state and event decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESS1;
            end
         end

         PRESS1: begin
            // Release takes priority over a coincident long expiry.
            if (!db) begin
               state_d = GAP;
            end else if (long_hit) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
            end
         end

         LONG_HELD: begin
            if (!db) begin
               state_d = IDLE;
            end
         end

         GAP: begin
            // A rise on the same edge as gap expiry still counts as a
            // double click.
            if (rise) begin
               state_d  = PRESS2;
               double_d = 1'b1;
            end else if (gap_hit) begin
               state_d = IDLE;
               short_d = 1'b1;
            end
         end

         PRESS2: begin
            // Holding the second press never escalates to a long press.
            if (!db) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Millisecond timer next-state
   // ------------------------------------------------------------------------
   // The timer restarts on every state change so each state measures its
   // own dwell time from the entering edge. It is held at zero in IDLE since
   // nothing there depends on elapsed time.
   always_comb begin
      presc_d  = presc_q;
      ms_cnt_d = ms_cnt_q;

      if ((state_d != state_q) || (state_q == IDLE)) begin
         presc_d  = '0;
         ms_cnt_d = '0;
      end else if (ms_tick) begin
         presc_d = '0;
         if (ms_cnt_q != MS_SAT) begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
         end
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         ms_cnt_q  <= '0;
         db_prev_q <= 1'b1;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         double_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         ms_cnt_q  <= ms_cnt_d;
         db_prev_q <= db;
         short_q   <= short_d;
         long_q    <= long_d;
         double_q  <= double_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Each event is decoded on a distinct transition, so at most one strobe
   // is ever high in a given cycle.
   assign short_tick  = short_q;
   assign long_tick   = long_q;
   assign double_tick = double_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_press_classifier
//
// Drives db as a per-edge waveform (lev[k] is the level sampled at clock edge
// k after reset release). A reference model walks the waveform using the
// gesture rules (press run lengths and gap lengths measured in edges) and
// builds the expected strobe / busy value seen after every edge.
// -----------------------------------------------------------------------------
module tb_press_classifier;

   localparam int TICK_M    = 4;
   localparam int LONG_MS   = 5;
   localparam int DCLICK_MS = 3;
   localparam int LONG_CYC  = LONG_MS * TICK_M;     // 20 edges
   localparam int GAP_CYC   = DCLICK_MS * TICK_M;   // 12 edges
   localparam int MAXN      = 600;

   logic clk;
   logic reset;
   logic db;
   logic short_tick;
   logic long_tick;
   logic double_tick;
   logic busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   bit lev        [0:MAXN-1];
   bit exp_short  [0:MAXN-1];
   bit exp_long   [0:MAXN-1];
   bit exp_double [0:MAXN-1];
   bit exp_busy   [0:MAXN-1];

   press_classifier #(
      .TICK_M    (TICK_M),
      .LONG_MS   (LONG_MS),
      .DCLICK_MS (DCLICK_MS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .db          (db),
      .short_tick  (short_tick),
      .long_tick   (long_tick),
      .double_tick (double_tick),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   // Level before edge 0 is treated as high: a button held through reset
   // must be released before a press is recognised.
   function automatic bit is_rise(input int k);
      bit p;
      p = (k == 0) ? 1'b1 : lev[k-1];
      return lev[k] && !p;
   endfunction

   task automatic build_expect(input int n);
      int k;
      int e0;
      int r;
      int g0;
      int q;
      int s;
      int idle;
      for (int i = 0; i < n; i++) begin
         exp_short[i]  = 1'b0;
         exp_long[i]   = 1'b0;
         exp_double[i] = 1'b0;
         exp_busy[i]   = 1'b0;
      end
      k = 0;
      while (k < n) begin
         if (!is_rise(k)) begin
            k++;
         end else begin
            e0 = k;
            // first edge at which the press is seen released
            r = e0 + 1;
            while (r < n && lev[r]) r++;
            if (r > e0 + LONG_CYC) begin
               exp_long[e0 + LONG_CYC] = 1'b1;
               idle = r;
            end else if (r >= n) begin
               idle = n;
            end else begin
               g0 = r;
               q  = g0 + 1;
               while (q < n && !lev[q]) q++;
               if (q < n && q <= g0 + GAP_CYC) begin
                  exp_double[q] = 1'b1;
                  s = q + 1;
                  while (s < n && lev[s]) s++;
                  idle = s;
               end else begin
                  if (g0 + GAP_CYC < n) exp_short[g0 + GAP_CYC] = 1'b1;
                  idle = g0 + GAP_CYC;
               end
            end
            for (int i = e0; i < idle && i < n; i++) exp_busy[i] = 1'b1;
            k = idle + 1;
         end
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   // Ends between a falling and the next rising edge with reset released.
   task automatic do_reset(input bit db_level);
      @(negedge clk);
      reset = 1'b1;
      db    = db_level;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   // Appends a run of 'len' edges at 'level' starting at index 'pos'.
   task automatic put_run(inout int pos, input bit level, input int len);
      for (int j = 0; j < len && pos < MAXN; j++) begin
         lev[pos] = level;
         pos++;
      end
   endtask

   // Plays lev[0..n-1] and compares the outputs after every edge.
   task automatic run_wave(input int n, input string name);
      int ns;
      int nl;
      int nd;
      ns = 0;
      nl = 0;
      nd = 0;
      build_expect(n);
      for (int k = 0; k < n; k++) begin
         db = lev[k];
         @(posedge clk);
         #1;
         total_cnt++;
         if (short_tick !== exp_short[k])
            $display("FAIL %s short_tick edge %0d: got %b expected %b", name, k, short_tick, exp_short[k]);
         else
            pass_cnt++;
         total_cnt++;
         if (long_tick !== exp_long[k])
            $display("FAIL %s long_tick edge %0d: got %b expected %b", name, k, long_tick, exp_long[k]);
         else
            pass_cnt++;
         total_cnt++;
         if (double_tick !== exp_double[k])
            $display("FAIL %s double_tick edge %0d: got %b expected %b", name, k, double_tick, exp_double[k]);
         else
            pass_cnt++;
         total_cnt++;
         if (busy !== exp_busy[k])
            $display("FAIL %s busy edge %0d: got %b expected %b", name, k, busy, exp_busy[k]);
         else
            pass_cnt++;
         total_cnt++;
         if ((int'(short_tick) + int'(long_tick) + int'(double_tick)) > 1)
            $display("FAIL %s onehot edge %0d: got %b%b%b expected at most one high", name, k, short_tick, long_tick, double_tick);
         else
            pass_cnt++;
         if (exp_short[k])  ns++;
         if (exp_long[k])   nl++;
         if (exp_double[k]) nd++;
         @(negedge clk);
      end
      $display("scenario %s: %0d edges, expected short=%0d long=%0d double=%0d", name, n, ns, nl, nd);
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      db    = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({short_tick, long_tick, double_tick, busy} !== 4'b0000)
         $display("FAIL reset outputs: got %b expected 0000", {short_tick, long_tick, double_tick, busy});
      else
         pass_cnt++;
      reset = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         total_cnt++;
         if ({short_tick, long_tick, double_tick, busy} !== 4'b0000)
            $display("FAIL reset idle outputs: got %b expected 0000", {short_tick, long_tick, double_tick, busy});
         else
            pass_cnt++;
      end
      $display("scenario reset: outputs checked during and after reset");
   endtask

   task automatic test_short_press();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, 8);
      put_run(p, 1'b0, 20);
      run_wave(p, "short_press");
   endtask

   task automatic test_long_press();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, 25);
      put_run(p, 1'b0, 16);
      run_wave(p, "long_press");
   endtask

   task automatic test_double_click();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, 6);
      put_run(p, 1'b0, 5);
      put_run(p, 1'b1, 6);
      put_run(p, 1'b0, 16);
      run_wave(p, "double_click");
   endtask

   // Release sampled exactly at E0+LONG_CYC: no long, short follows.
   task automatic test_long_boundary();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, LONG_CYC);
      put_run(p, 1'b0, 18);
      run_wave(p, "long_boundary");
   endtask

   // Rise sampled exactly at G0+GAP_CYC: double, not short.
   task automatic test_gap_boundary();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, 5);
      put_run(p, 1'b0, GAP_CYC);
      put_run(p, 1'b1, 4);
      put_run(p, 1'b0, 16);
      run_wave(p, "gap_boundary");
   endtask

   // Followed immediately by a new press to show back-to-back gestures.
   task automatic test_back_to_back();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 1);
      put_run(p, 1'b1, 3);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, 3);
      put_run(p, 1'b0, 1);
      put_run(p, 1'b1, 22);
      put_run(p, 1'b0, 1);
      put_run(p, 1'b1, 4);
      put_run(p, 1'b0, 15);
      run_wave(p, "back_to_back");
   endtask

   task automatic test_held_through_reset();
      int p;
      p = 0;
      do_reset(1'b1);
      put_run(p, 1'b1, 30);
      put_run(p, 1'b0, 4);
      put_run(p, 1'b1, 8);
      put_run(p, 1'b0, 16);
      run_wave(p, "held_through_reset");
   endtask

   task automatic test_reset_mid_gap();
      int p;
      p = 0;
      do_reset(1'b0);
      put_run(p, 1'b0, 2);
      put_run(p, 1'b1, 5);
      put_run(p, 1'b0, 6);
      run_wave(p, "mid_gap_pre");
      #2;
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({short_tick, long_tick, double_tick, busy} !== 4'b0000)
         $display("FAIL mid_gap_reset outputs: got %b expected 0000", {short_tick, long_tick, double_tick, busy});
      else
         pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      p = 0;
      put_run(p, 1'b0, 24);
      run_wave(p, "mid_gap_post");
   endtask

   task automatic test_random();
      int p;
      int len;
      bit lvl;
      string nm;
      for (int it = 0; it < 4; it++) begin
         lvl = 1'($urandom_range(0, 1));
         do_reset(lvl);
         p = 0;
         while (p < 500) begin
            case ($urandom_range(0, 5))
               0:       len = LONG_CYC + $urandom_range(0, 2) - 1;
               1:       len = GAP_CYC + $urandom_range(0, 2) - 1;
               default: len = $urandom_range(1, 30);
            endcase
            put_run(p, lvl, len);
            lvl = !lvl;
         end
         nm = $sformatf("random_%0d", it);
         run_wave(500, nm);
      end
   endtask

   initial begin
      reset = 1'b1;
      db    = 1'b0;
      test_reset();
      test_short_press();
      test_long_press();
      test_double_click();
      test_long_boundary();
      test_gap_boundary();
      test_back_to_back();
      test_held_through_reset();
      test_reset_mid_gap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/press_classifier.md
# press_classifier

Gesture classifier that consumes the debounced level from the early debouncer and turns it into single-cycle events: short press, long press, and double click. It sits between the debouncer output and the application control logic, so downstream logic receives clean one-cycle strobes instead of raw level timing. Timing is measured in milliseconds from an internal prescaler, so the block needs no external tick.

## Interface
- TICK_M, 100_000, clk cycles per 1 ms tick (100 MHz clk)
- LONG_MS, 500, hold duration in ms that qualifies a long press
- DCLICK_MS, 250, maximum release gap in ms for a double click
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- db  in  1  debounced button level, synchronous to clk
- short_tick  out  1  one-cycle pulse: short press completed
- long_tick  out  1  one-cycle pulse: long-press threshold reached
- double_tick  out  1  one-cycle pulse: second press of a double click
- busy  out  1  high whenever state != IDLE

## Operation
- Edge detect: db_prev register; rise = db & ~db_prev. db_prev resets to 1, so a button held through reset is ignored until it is released and pressed again.
- Prescaler: counts 0..TICK_M-1. ms_tick = (presc == TICK_M-1).
- ms_cnt: increments on ms_tick and saturates at its max.
  - Width = $clog2(max(LONG_MS, DCLICK_MS)+1).
  - Prescaler and ms_cnt are both cleared on every state transition.
- States: IDLE, PRESS1, LONG_HELD, GAP, PRESS2.
- IDLE: rise -> PRESS1.
- PRESS1: checked in priority order:
  - db==0 -> GAP.
  - else if ms_tick & ms_cnt==LONG_MS-1 -> LONG_HELD, and assert long_tick.
- LONG_HELD: db==0 -> IDLE. No further event is generated.
- GAP: checked in priority order:
  - rise -> PRESS2, and assert double_tick.
  - else if ms_tick & ms_cnt==DCLICK_MS-1 -> IDLE, and assert short_tick.
- PRESS2: db==0 -> IDLE. Holding the second press does not produce long_tick.
- Outputs are registered, high for exactly the one cycle following the transitioning edge. At most one event output is high in any cycle.
- Reset: state=IDLE, presc=0, ms_cnt=0, db_prev=1, all outputs 0. Reset acts immediately, including mid-gesture; an aborted gesture never produces a late event.

## Timing
- Let E0 be the edge that enters PRESS1 (the first edge sampling db high after a low).
- long_tick: high in the cycle after edge E0 + LONG_MS·TICK_M, when db is still high at that edge.
- Simultaneous release and long expiry at the same edge: release wins. The block goes to GAP and no long_tick is generated.
- Let G0 be the edge that enters GAP. short_tick: high after edge G0 + DCLICK_MS·TICK_M, if no rise occurred at any edge up to and including that one.
- Simultaneous rise and gap expiry at the same edge: rise wins, giving double_tick.
- double_tick: high in the cycle after the first edge sampling db high while in GAP. Latency is 1 cycle from the sampled rise.
- busy:
  - rises the cycle after E0;
  - falls the cycle after the edge entering IDLE.
- Throughput: a new gesture may begin in the cycle immediately after returning to IDLE.

## Test plan
Bench parameters: TICK_M=4, LONG_MS=5, DCLICK_MS=3, giving a long threshold of 20 cycles and a gap window of 12 cycles.

- Short press: reset with db=0; db high 8 cycles, then low -> short_tick for exactly 1 cycle after edge G0+12; long_tick and double_tick stay 0; busy low the next cycle.
- Long press: db high 25 cycles -> long_tick for 1 cycle after edge E0+20. Release -> no further pulse; busy drops 1 cycle after the release edge.
- Double click: db high 6, low 5, high 6, low -> double_tick for 1 cycle after the second rise; short_tick is never asserted.
- Boundary cases:
  - db sampled low exactly at edge E0+20 -> no long_tick; short_tick follows 12 cycles later.
  - Rise at exactly G0+12 -> double_tick, no short_tick.
- Reset interactions:
  - db held high across reset deassertion -> no event and busy=0 until db goes low then high again.
  - Reset pulsed mid-GAP -> outputs 0 at once; no short_tick afterwards.
